// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer.
// Optional perf counter in systolic_sequencer is enabled by SEQ_PERF_CNT_EN.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MULT = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam int DEFAULT_MATRIX_SIZE = 2;
    localparam int DEFAULT_STEP_CYCLES = 4;
    localparam int DEFAULT_TILE_W      = 8;

    // Index width that never collapses to zero bits for a size of 1.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/systolic_step_timer.sv
// Wavefront step timer: divides the clock by STEP_CYCLES and counts steps.
// clear has priority over enable so a cancelled or finished pass restarts at step 0.
module systolic_step_timer
    import systolic_pkg::*;
#(
    parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES,
    parameter int STEP_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    output logic              step_tick,
    output logic [STEP_W-1:0] step
);

    localparam int CNT_W = clog2_min1(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign step_tick = enable && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            step <= '0;
        end else if (clear) begin
            cnt  <= '0;
            step <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                step <= step + STEP_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Control sequencer for an N x N systolic array: per-tile weight load then skewed multiply wavefront.
// Define SEQ_PERF_CNT_EN to add the perf_cycles busy-cycle counter output.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
    parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES,
    parameter int TILE_W      = DEFAULT_TILE_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                general_enable,
    input  logic                                start,
    input  logic                                abort,
    input  logic [TILE_W-1:0]                   tile_count,
    output logic [MATRIX_SIZE-1:0]              load_weight,
    output logic [clog2_min1(MATRIX_SIZE)-1:0]  weight_row_sel,
    output logic [MATRIX_SIZE-1:0]              enable_mult,
    output logic                                busy,
    output logic                                done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_cycles
`endif
);

    localparam int unsigned N      = MATRIX_SIZE;
    localparam int          ROW_W  = clog2_min1(MATRIX_SIZE);
    localparam int          STEP_W = clog2_min1(2 * MATRIX_SIZE);

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(MATRIX_SIZE - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * MATRIX_SIZE - 2);

    seq_state_t        state, state_next;
    logic [ROW_W-1:0]  row, row_next;
    logic [TILE_W-1:0] tiles_left, tiles_next;
    logic [STEP_W-1:0] step;
    logic              step_tick;
    logic              mult_last;
    logic              timer_clear;

    assign mult_last   = (state == ST_MULT) && step_tick && (step == STEP_LAST);
    assign timer_clear = abort || (state != ST_MULT) || mult_last;

    systolic_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .STEP_W      (STEP_W)
    ) u_step_timer (
        .clk       (clk),
        .reset     (reset),
        .enable    (general_enable),
        .clear     (timer_clear),
        .step_tick (step_tick),
        .step      (step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            row        <= '0;
            tiles_left <= '0;
        end else begin
            state      <= state_next;
            row        <= row_next;
            tiles_left <= tiles_next;
        end
    end

    // abort wins over both start and a deasserted general_enable
    always_comb begin
        state_next = state;
        row_next   = row;
        tiles_next = tiles_left;
        if (abort) begin
            state_next = ST_IDLE;
            row_next   = '0;
            tiles_next = '0;
        end else if (general_enable) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_LOAD;
                        row_next   = '0;
                        tiles_next = (tile_count == '0) ? TILE_W'(1) : tile_count;
                    end
                end
                ST_LOAD: begin
                    if (row == ROW_LAST) begin
                        state_next = ST_MULT;
                        row_next   = '0;
                    end else begin
                        row_next = row + ROW_W'(1);
                    end
                end
                ST_MULT: begin
                    if (mult_last) begin
                        tiles_next = tiles_left - TILE_W'(1);
                        state_next = (tiles_left == TILE_W'(1)) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Row r of the array is active for wavefront steps r .. r+N-1.
    always_comb begin
        load_weight    = '0;
        weight_row_sel = '0;
        enable_mult    = '0;
        if (state == ST_LOAD) begin
            load_weight    = MATRIX_SIZE'(1) << row;
            weight_row_sel = row;
        end
        if (state == ST_MULT) begin
            for (int unsigned r = 0; r < N; r++) begin
                if ((r <= 32'(step)) && (32'(step) <= r + N - 1)) begin
                    enable_mult[r] = 1'b1;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (abort) begin
            perf_cycles <= '0;
        end else if (general_enable) begin
            if ((state == ST_IDLE) && start) begin
                perf_cycles <= '0;
            end else if (state != ST_IDLE) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed self-checking bench for systolic_sequencer (N=2, STEP_CYCLES=4).
// Build with SEQ_PERF_CNT_EN defined to also check perf_cycles.
module tb_systolic_sequencer;

    logic       clk;
    logic       reset;
    logic       general_enable;
    logic       start;
    logic       abort;
    logic [7:0] tile_count;
    logic [1:0] load_weight;
    logic [0:0] weight_row_sel;
    logic [1:0] enable_mult;
    logic       busy;
    logic       done;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    systolic_sequencer #(
        .MATRIX_SIZE (2),
        .STEP_CYCLES (4),
        .TILE_W      (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .general_enable (general_enable),
        .start          (start),
        .abort          (abort),
        .tile_count     (tile_count),
        .load_weight    (load_weight),
        .weight_row_sel (weight_row_sel),
        .enable_mult    (enable_mult),
        .busy           (busy),
        .done           (done)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles    (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {load_weight, weight_row_sel, enable_mult, busy, done};
    endfunction

    // Hand-derived outputs {lw,sel,em,busy,done} for job cycle j (cycle 1 follows the start edge).
    // Each tile: 2 load cycles then 12 multiply cycles (em 01 x4, 11 x4, 10 x4).
    function automatic logic [6:0] exp_job(input int j, input int tiles);
        int t;
        if (j < 1 || j > 14 * tiles + 1) return 7'b00_0_00_0_0;
        if (j == 14 * tiles + 1)         return 7'b00_0_00_1_1;
        t = (j - 1) % 14;
        if (t == 0) return 7'b01_0_00_1_0;
        if (t == 1) return 7'b10_1_00_1_0;
        if (t < 6)  return 7'b00_0_01_1_0;
        if (t < 10) return 7'b00_0_11_1_0;
        return 7'b00_0_10_1_0;
    endfunction

    task automatic run_job(input string tag, input int tiles, input int ncyc, input int poke_start);
        for (int j = 1; j <= ncyc; j++) begin
            start = (j == poke_start);
            chk($sformatf("%s_c%0d", tag, j), 32'(outs()), 32'(exp_job(j, tiles)));
            tick();
        end
        start = 1'b0;
    endtask

    task automatic launch(input logic [7:0] tiles);
        start      = 1'b1;
        tile_count = tiles;
        tick();
        start      = 1'b0;
        tile_count = 8'hA5;
    endtask

    initial begin
        int j;
        reset          = 1'b1;
        general_enable = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        tile_count     = 8'd0;

        #2 reset = 1'b0;
        #1 chk("reset_outs", 32'(outs()), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("idle_after_reset", 32'(outs()), 32'd0);

        // Single tile
        launch(8'd1);
        run_job("single", 1, 17, 0);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_single", perf_cycles, 32'd15);
        tick();
        chk("perf_hold", perf_cycles, 32'd15);
`endif

        // Three tiles, stray start mid-job must be ignored
        launch(8'd3);
        run_job("multi", 3, 44, 20);

        // Enable low 5 cycles in MULT step 1, and 2 cycles during DONE
        launch(8'd1);
        j = 1;
        for (int c = 1; c <= 23; c++) begin
            general_enable = !((c >= 8 && c <= 12) || (c >= 20 && c <= 21));
            chk($sformatf("freeze_c%0d", c), 32'(outs()), 32'(exp_job(j, 1)));
            tick();
            if (general_enable) j++;
        end
        general_enable = 1'b1;

        // Abort in cycle 7
        launch(8'd1);
        run_job("pre_abort", 1, 6, 0);
        chk("abort_c7", 32'(outs()), 32'(exp_job(7, 1)));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int c = 8; c <= 20; c++) begin
            chk($sformatf("aborted_c%0d", c), 32'(outs()), 32'd0);
            tick();
        end

        // Abort together with start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", 32'(outs()), 32'd0);
        tick();
        chk("abort_start_idle2", 32'(outs()), 32'd0);

        // Abort overrides a deasserted enable
        launch(8'd2);
        general_enable = 1'b0;
        abort          = 1'b1;
        tick();
        abort          = 1'b0;
        general_enable = 1'b1;
        chk("abort_no_enable", 32'(outs()), 32'd0);

        // New job after abort runs normally
        launch(8'd1);
        run_job("post_abort", 1, 17, 0);

        // Asynchronous reset in LOAD
        launch(8'd2);
        chk("pre_async_reset", 32'(outs()), 32'(exp_job(1, 2)));
        #2 reset = 1'b0;
        #1 chk("async_reset", 32'(outs()), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("after_async_reset", 32'(outs()), 32'd0);

        // tile_count of 0 runs one tile
        launch(8'd0);
        run_job("zero_tiles", 1, 17, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
